// File: rtl/ysyx_22041752_mem_stage_pkg.sv
// Shared definitions for the memory-access stage.
// Holds the bus widths, the mem_bytes size encodings, the load FSM state
// encodings and the packed layout of the execute-to-memory bus.
package ysyx_22041752_mem_stage_pkg;

  localparam int PC_WD             = 64;
  localparam int DATA_WD           = 64;
  localparam int RF_ADDR_WD        = 5;
  localparam int ES_TO_MS_BUS_WD   = 139;
  localparam int MS_TO_WS_BUS_WD   = 134;
  localparam int MS_FORWARD_BUS_WD = 71;

  // Access size of a load
  localparam logic [1:0] MB_BYTE  = 2'b00;
  localparam logic [1:0] MB_HALF  = 2'b01;
  localparam logic [1:0] MB_WORD  = 2'b10;
  localparam logic [1:0] MB_DWORD = 2'b11;

  // Load FSM states
  localparam logic [1:0] ST_IDLE = 2'd0;  // no load outstanding
  localparam logic [1:0] ST_WAIT = 2'd1;  // waiting for the SRAM response
  localparam logic [1:0] ST_DONE = 2'd2;  // response buffered, write-back stalled

  // Field layout of es_to_ms_bus, MSB first
  typedef struct packed {
    logic                  res_sext;
    logic                  res_zext;
    logic [1:0]            mem_bytes;
    logic                  mem_re;
    logic                  rf_we;
    logic [RF_ADDR_WD-1:0] rd;
    logic [DATA_WD-1:0]    alu_result;
    logic [PC_WD-1:0]      pc;
  } es_to_ms_t;

endpackage

// File: rtl/ysyx_22041752_load_ext.sv
// Load lane select and extension (purely combinational).
//   word      : aligned doubleword returned by the data SRAM
//   off       : byte offset of the access within the doubleword
//   mem_bytes : access size (byte/half/word/dword)
//   res_zext  : 1 = zero-extend, 0 = sign-extend
//   value     : extended 64-bit load result
// Misaligned accesses are not trapped: result lane i is taken from byte lane
// (off+i) mod 8, so lanes past the top of the doubleword wrap around.
module ysyx_22041752_load_ext
  import ysyx_22041752_mem_stage_pkg::*;
(
  input  logic [DATA_WD-1:0] word,
  input  logic [2:0]         off,
  input  logic [1:0]         mem_bytes,
  input  logic               res_zext,
  output logic [DATA_WD-1:0] value
);

  logic [DATA_WD-1:0] rot;

  // Byte-rotate so the addressed byte lands in lane 0
  always_comb begin
    logic [2:0] lane;
    rot  = '0;
    lane = '0;
    for (int i = 0; i < 8; i++) begin
      lane = off + 3'(i);
      rot[8*i +: 8] = word[{lane, 3'b000} +: 8];
    end
  end

  always_comb begin
    value = rot;
    case (mem_bytes)
      MB_BYTE: value = {{56{~res_zext & rot[7]}},  rot[7:0]};
      MB_HALF: value = {{48{~res_zext & rot[15]}}, rot[15:0]};
      MB_WORD: value = {{32{~res_zext & rot[31]}}, rot[31:0]};
      default: value = rot;
    endcase
  end

endmodule

// File: rtl/ysyx_22041752_mem_stage.sv
// Memory-access pipeline stage.
// Holds one instruction from execute; non-loads pass their ALU result
// through with no added latency, loads wait for the one-cycle SRAM response
// strobe, then extract and extend the addressed lanes.
//   clk, reset        : clock, asynchronous active-low reset
//   ws_allowin        : write-back can accept this cycle
//   ms_allowin        : this stage can accept this cycle
//   es_to_ms_valid/bus: instruction from execute
//   ms_to_ws_valid/bus: {rf_we, rd, final_result, pc} to write-back
//   data_sram_rvalid/rdata : load response strobe and doubleword
//   ms_forward_bus    : {load_pending, fwd_valid, final_result, rd} to decode
//   debug_ms_pc       : pc of the held instruction
module ysyx_22041752_mem_stage
  import ysyx_22041752_mem_stage_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ws_allowin,
  output logic                         ms_allowin,
  input  logic                         es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0]   es_to_ms_bus,
  output logic                         ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0]   ms_to_ws_bus,
  input  logic                         data_sram_rvalid,
  input  logic [DATA_WD-1:0]           data_sram_rdata,
  output logic [MS_FORWARD_BUS_WD-1:0] ms_forward_bus,
  output logic [PC_WD-1:0]             debug_ms_pc
);

  es_to_ms_t          in_bus, bus_r;
  logic               ms_valid, ms_ready_go, accept, load_pending;
  logic [1:0]         state, state_nxt;
  logic [DATA_WD-1:0] rdata_buf, load_word, load_value, final_result;
  logic               sext_unused;

  assign in_bus      = es_to_ms_bus;
  // Sign extension is the default whenever res_zext is clear
  assign sext_unused = bus_r.res_sext;

  assign ms_ready_go    = !bus_r.mem_re || (state == ST_WAIT && data_sram_rvalid) ||
                          state == ST_DONE;
  assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_valid && ms_ready_go;
  assign accept         = es_to_ms_valid && ms_allowin;

  // Whenever the stage accepts, the held instruction has retired (or the
  // stage was empty), so the FSM restarts from the incoming instruction.
  always_comb begin
    state_nxt = state;
    if (ms_allowin)
      state_nxt = (accept && in_bus.mem_re) ? ST_WAIT : ST_IDLE;
    else if (state == ST_WAIT && data_sram_rvalid)
      state_nxt = ST_DONE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ms_valid  <= 1'b0;
      state     <= ST_IDLE;
      rdata_buf <= '0;
      bus_r     <= '0;
    end else begin
      if (ms_allowin) ms_valid <= es_to_ms_valid;
      if (accept) bus_r <= in_bus;
      if (state == ST_WAIT && data_sram_rvalid) rdata_buf <= data_sram_rdata;
      state <= state_nxt;
    end
  end

  assign load_word = (state == ST_DONE) ? rdata_buf : data_sram_rdata;

  ysyx_22041752_load_ext u_load_ext (
    .word      (load_word),
    .off       (bus_r.alu_result[2:0]),
    .mem_bytes (bus_r.mem_bytes),
    .res_zext  (bus_r.res_zext),
    .value     (load_value)
  );

  assign final_result = bus_r.mem_re ? load_value : bus_r.alu_result;
  assign load_pending = ms_valid && bus_r.mem_re && !ms_ready_go;

  assign ms_to_ws_bus   = {bus_r.rf_we, bus_r.rd, final_result, bus_r.pc};
  assign ms_forward_bus = {load_pending, ms_valid && bus_r.rf_we, final_result, bus_r.rd};
  assign debug_ms_pc    = bus_r.pc;

endmodule

// File: doc/ysyx_22041752_mem_stage.md
Name: ysyx_22041752_mem_stage

Overview:
- Memory-access pipeline stage directly downstream of the execute stage.
- Accepts the execute-to-memory bus and completes loads when the data SRAM returns its response: byte-lane extraction plus sign/zero extension.
- Passes ALU results straight through for non-load instructions.
- Drives the write-back bus, and a forward bus used by decode for bypass and load-use stall decisions.

Parameters:
- PC_WD, 64, program-counter width
- DATA_WD, 64, register and SRAM data width
- RF_ADDR_WD, 5, register index width
- ES_TO_MS_BUS_WD, 139, input bus width
- MS_TO_WS_BUS_WD, 134, output bus width
- MS_FORWARD_BUS_WD, 71, forward bus width

Ports:
- clk  in  1  single clock
- reset  in  1  asynchronous, active-low reset
- ws_allowin  in  1  write-back stage can accept
- ms_allowin  out  1  this stage can accept
- es_to_ms_valid  in  1  input bus valid
- es_to_ms_bus  in  139  {res_sext, res_zext, mem_bytes[1:0], mem_re, rf_we, rd[4:0], alu_result[63:0], pc[63:0]}
- ms_to_ws_valid  out  1  output bus valid
- ms_to_ws_bus  out  134  {rf_we, rd[4:0], final_result[63:0], pc[63:0]}
- data_sram_rvalid  in  1  one-cycle read-response strobe
- data_sram_rdata  in  64  aligned doubleword containing the load address
- ms_forward_bus  out  71  {load_pending, fwd_valid, final_result[63:0], rd[4:0]}
- debug_ms_pc  out  64  pc of the held instruction

Behaviour:
Reset:
- While reset is low: ms_valid=0, state=IDLE, rdata_buf=0, bus_r=0.
- Resulting outputs: ms_allowin=1, ms_to_ws_valid=0, ms_forward_bus fwd_valid=0 and load_pending=0, debug_ms_pc=0.

Input capture:
- bus_r is loaded when es_to_ms_valid && ms_allowin.
- ms_valid is loaded with es_to_ms_valid whenever ms_allowin=1.

Load state machine:
- IDLE: no load outstanding. On accepting an instruction with mem_re=1, go to WAIT.
- WAIT: waiting for the response. On data_sram_rvalid: capture rdata_buf. If ws_allowin=1 in the same cycle, retire directly (back to IDLE, or to WAIT if a new load is accepted that cycle); otherwise go to DONE.
- DONE: data buffered. When ws_allowin=1, go to IDLE (or to WAIT if a new load is accepted that cycle).
- data_sram_rvalid is ignored in IDLE and DONE. The bench flags this as a protocol error.
- Minimum response latency is 1 cycle after capture into this stage. A load issues exactly one response.

Handshake:
- ms_ready_go = !mem_re || (state==WAIT && data_sram_rvalid) || state==DONE.
- ms_allowin = !ms_valid || (ms_ready_go && ws_allowin).
- ms_to_ws_valid = ms_valid && ms_ready_go.
- Non-load instructions have zero added latency.

Load data path:
- Select word = state==DONE ? rdata_buf : data_sram_rdata.
- off = alu_result[2:0].
- mem_bytes: 00 = byte word[8*off+:8]; 01 = half word[8*off+:16]; 10 = word word[8*off+:32]; 11 = full 64 bits.
- Extension: res_zext=1 gives zero-extend to 64. Otherwise sign-extend (res_sext and default).
- Misalignment is not checked. Off-boundary offsets take the lanes selected by off within the doubleword; the upper lanes wrap as truncated indexing.

Result selection:
- final_result = mem_re ? load_value : alu_result.

Forward bus:
- load_pending = ms_valid && mem_re && !ms_ready_go.
- fwd_valid = ms_valid && rf_we.
- final_result is only meaningful when load_pending=0.

Other rules:
- No flush input. Cancellation happens upstream by dropping es_to_ms_valid.
- A reset asserted mid-WAIT discards the pending response. A late rvalid after reset release is ignored because state is IDLE.
- Simultaneous retire and accept in the same cycle is legal and yields back-to-back throughput of 1 per cycle.

Decomposition:
- Shared header holds:
  - the bus width macros (ES_TO_MS_BUS_WD, MS_TO_WS_BUS_WD, MS_FORWARD_BUS_WD)
  - mem_bytes encodings (BYTE=2'b00, HALF=2'b01, WORD=2'b10, DWORD=2'b11)
  - state encodings IDLE/WAIT/DONE
- One natural sub-module, ysyx_22041752_load_ext: purely combinational lane select plus extension from (word, off, mem_bytes, res_zext).

Test Plan:
- ALU passthrough: bus with mem_re=0, rf_we=1, rd=5, alu_result=0x1234, ws_allowin=1 -> ms_to_ws_valid the cycle after capture, final_result=0x1234, rd=5, fwd_valid=1, load_pending=0.
- Signed byte load: lb, alu_result=0x80000003, rdata=0x00000000_AB000000 arriving 2 cycles after capture -> load_pending=1 for 2 cycles, then final_result=0xFFFFFFFF_FFFFFFAB.
- Unsigned half load with write-back stall: lhu, off=6, rdata=0x8001_0000_0000_0000, ws_allowin=0 for 3 cycles after rvalid -> state DONE holds, ms_allowin=0, final_result=0x0000_0000_0000_8001 stable until ws_allowin=1.
- Back-to-back: ld followed by add with rvalid in the first WAIT cycle and ws_allowin=1 -> ld retires and add is accepted the same cycle, with no bubble.
- Reset mid-WAIT: reset pulled low during WAIT, then rvalid after release -> ms_valid=0, no ms_to_ws_valid, state stays IDLE.
- Word sign-extend: lw off=4, rdata=0x80000000_00000000 -> 0xFFFFFFFF_80000000; lwu on the same data -> 0x00000000_80000000.
